// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline WB vs. buffered mul/div results.
// Optional WB_WAW_CHECK_EN adds a sticky waw_err flag for WB hitting a busy reg.
module wb_write_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_en,
  input  logic [4:0]    wb_reg,
  input  logic [31:0]   wb_data,
  input  logic          mc_issue,
  input  logic [4:0]    mc_issue_reg,
  input  logic          mc_valid,
  input  logic [4:0]    mc_reg,
  input  logic [31:0]   mc_data,
  output logic          mc_ready,
  output logic          write_en,
  output logic [4:0]    writeReg,
  output logic [31:0]   write_data,
  output logic [31:0]   busy,
  output logic [AW:0]   fifo_count
`ifdef WB_WAW_CHECK_EN
  ,
  output logic          waw_err
`endif
);

  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  logic [4:0]    r_mem_reg  [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_count;
  logic          r_write_en;
  logic [4:0]    r_write_reg;
  logic [31:0]   r_write_data;
  logic [31:0]   r_busy;

  logic          w_ready;
  logic          w_acc;
  logic          w_wb;
  logic          w_empty;
  logic          w_pop;
  logic          w_bypass;
  logic          w_push;
  logic          w_clr;
  logic [4:0]    w_clr_reg;
  logic [4:0]    w_head_reg;
  logic [31:0]   w_head_data;
  logic [31:0]   w_busy_nxt;

  assign w_ready     = (r_count != LP_FULL);
  assign w_acc       = mc_valid & w_ready;
  assign w_wb        = wb_en & (wb_reg != 5'd0);
  assign w_empty     = (r_count == '0);
  assign w_pop       = ~w_wb & ~w_empty;
  assign w_bypass    = ~w_wb & w_empty & w_acc
                     & (mc_reg != 5'd0);
  assign w_push      = w_acc & (mc_reg != 5'd0)
                     & ~w_bypass;
  assign w_head_reg  = r_mem_reg[r_rd];
  assign w_head_data = r_mem_data[r_rd];
  assign w_clr       = w_pop | w_bypass;
  assign w_clr_reg   = w_pop ? w_head_reg : mc_reg;

  // set after clear so a same-cycle issue keeps its register busy
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_clr)
      w_busy_nxt[w_clr_reg] = 1'b0;
    if (mc_issue && (mc_issue_reg != 5'd0))
      w_busy_nxt[mc_issue_reg] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_reg[r_wr]  <= mc_reg;
      r_mem_data[r_wr] <= mc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd         <= '0;
      r_wr         <= '0;
      r_count      <= '0;
      r_write_en   <= 1'b0;
      r_write_reg  <= 5'd0;
      r_write_data <= 32'd0;
      r_busy       <= 32'd0;
    end else begin
      if (w_push)
        r_wr <= r_wr + 1'b1;
      if (w_pop)
        r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_write_en <= w_wb | w_pop | w_bypass;
      unique case (1'b1)
        w_wb: begin
          r_write_reg  <= wb_reg;
          r_write_data <= wb_data;
        end
        w_pop: begin
          r_write_reg  <= w_head_reg;
          r_write_data <= w_head_data;
        end
        w_bypass: begin
          r_write_reg  <= mc_reg;
          r_write_data <= mc_data;
        end
        default: ;
      endcase
      r_busy <= w_busy_nxt;
    end
  end

`ifdef WB_WAW_CHECK_EN
  logic r_waw;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_waw <= 1'b0;
    else if (w_wb && r_busy[wb_reg])
      r_waw <= 1'b1;
  end

  assign waw_err = r_waw;
`endif

  assign mc_ready   = w_ready;
  assign write_en   = r_write_en;
  assign writeReg   = r_write_reg;
  assign write_data = r_write_data;
  assign busy       = r_busy;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed cases plus random traffic
// checked against a queue-based reference model.
module tb_wb_write_arbiter;

  localparam int DEPTH = 2;
  localparam int AW    = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wb_en;
  logic [4:0]    wb_reg;
  logic [31:0]   wb_data;
  logic          mc_issue;
  logic [4:0]    mc_issue_reg;
  logic          mc_valid;
  logic [4:0]    mc_reg;
  logic [31:0]   mc_data;
  logic          mc_ready;
  logic          write_en;
  logic [4:0]    writeReg;
  logic [31:0]   write_data;
  logic [31:0]   busy;
  logic [AW:0]   fifo_count;
`ifdef WB_WAW_CHECK_EN
  logic          waw_err;
`endif

  wb_write_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_en        (wb_en),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .mc_issue     (mc_issue),
    .mc_issue_reg (mc_issue_reg),
    .mc_valid     (mc_valid),
    .mc_reg       (mc_reg),
    .mc_data      (mc_data),
    .mc_ready     (mc_ready),
    .write_en     (write_en),
    .writeReg     (writeReg),
    .write_data   (write_data),
    .busy         (busy),
    .fifo_count   (fifo_count)
`ifdef WB_WAW_CHECK_EN
    ,
    .waw_err      (waw_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic        m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  logic [31:0] m_busy;
  logic        m_waw;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic we,
                       input logic [4:0] wr,
                       input logic [31:0] wd,
                       input logic iss,
                       input logic [4:0] ir,
                       input logic mv,
                       input logic [4:0] mr,
                       input logic [31:0] md);
    ent_t e;
    bit   acc, used;
    if (!r) begin
      q.delete();
      m_we = 0; m_reg = 0; m_data = 0;
      m_busy = 0; m_waw = 0;
      return;
    end
    acc  = mv && (q.size() < DEPTH);
    used = 0;
    if (we && wr != 0 && m_busy[wr])
      m_waw = 1;
    if (we && wr != 0) begin
      m_we = 1; m_reg = wr; m_data = wd;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_we = 1; m_reg = e.r; m_data = e.d;
      m_busy[e.r] = 0;
    end else if (acc && mr != 0) begin
      m_we = 1; m_reg = mr; m_data = md;
      m_busy[mr] = 0;
      used = 1;
    end else begin
      m_we = 0;
    end
    if (acc && mr != 0 && !used) begin
      e.r = mr; e.d = md;
      q.push_back(e);
    end
    if (iss && ir != 0)
      m_busy[ir] = 1;
    m_busy[0] = 0;
  endtask

  task automatic step(input logic r, input logic we,
                      input logic [4:0] wr,
                      input logic [31:0] wd,
                      input logic iss,
                      input logic [4:0] ir,
                      input logic mv,
                      input logic [4:0] mr,
                      input logic [31:0] md);
    rst_n = r; wb_en = we; wb_reg = wr;
    wb_data = wd; mc_issue = iss;
    mc_issue_reg = ir; mc_valid = mv;
    mc_reg = mr; mc_data = md;
    model(r, we, wr, wd, iss, ir, mv, mr, md);
    @(posedge clk);
    @(negedge clk);
    chk("write_en", 64'(write_en), 64'(m_we));
    chk("writeReg", 64'(writeReg), 64'(m_reg));
    chk("write_data", 64'(write_data), 64'(m_data));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("fifo_count", 64'(fifo_count),
        64'(q.size()));
    chk("mc_ready", 64'(mc_ready),
        64'(q.size() < DEPTH));
`ifdef WB_WAW_CHECK_EN
    chk("waw_err", 64'(waw_err), 64'(m_waw));
`endif
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic r, we, iss, mv;
    logic [4:0] wr, ir, mr;

    // reset state
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_we", 64'(write_en), 64'd0);
    chk("rst_cnt", 64'(fifo_count), 64'd0);
    chk("rst_rdy", 64'(mc_ready), 64'd1);

    // plain WB write, 1-cycle latency
    step(1, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    chk("wb_we", 64'(write_en), 64'd1);
    chk("wb_reg", 64'(writeReg), 64'd5);
    chk("wb_dat", 64'(write_data), 64'hDEAD_BEEF);
    idle();
    chk("wb_we_off", 64'(write_en), 64'd0);

    // issue r7, then bypass result
    step(1, 0, 0, 0, 1, 7, 0, 0, 0);
    chk("b7_set", 64'(busy[7]), 64'd1);
    idle();
    chk("b7_hold", 64'(busy[7]), 64'd1);
    step(1, 0, 0, 0, 0, 0, 1, 7, 32'h1234);
    chk("byp_reg", 64'(writeReg), 64'd7);
    chk("byp_dat", 64'(write_data), 64'h1234);
    chk("b7_clr", 64'(busy[7]), 64'd0);

    // backlog under continuous WB
    step(1, 1, 3, 32'h33, 0, 0, 1, 8, 32'h80);
    step(1, 1, 3, 32'h33, 0, 0, 1, 9, 32'h90);
    chk("bk_cnt", 64'(fifo_count), 64'd2);
    chk("bk_rdy", 64'(mc_ready), 64'd0);
    step(1, 1, 3, 32'h33, 0, 0, 1, 10, 32'hA0);
    chk("bk_wb", 64'(writeReg), 64'd3);
    chk("bk_cnt2", 64'(fifo_count), 64'd2);
    step(1, 0, 0, 0, 0, 0, 1, 10, 32'hA0);
    chk("dr_8", 64'(writeReg), 64'd8);
    step(1, 0, 0, 0, 0, 0, 1, 10, 32'hA0);
    chk("dr_9", 64'(writeReg), 64'd9);
    idle();
    chk("dr_10", 64'(writeReg), 64'd10);
    chk("dr_10d", 64'(write_data), 64'hA0);
    idle();

    // set wins over drain clear on r4
    step(1, 0, 0, 0, 1, 4, 0, 0, 0);
    step(1, 1, 3, 32'h1, 0, 0, 1, 4, 32'h44);
    step(1, 0, 0, 0, 1, 4, 0, 0, 0);
    chk("sw_reg", 64'(writeReg), 64'd4);
    chk("sw_busy", 64'(busy[4]), 64'd1);

    // r0 targets are dropped
    step(1, 1, 0, 32'h5, 0, 0, 0, 0, 0);
    chk("z_wb", 64'(write_en), 64'd0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 32'h6);
    chk("z_mc", 64'(write_en), 64'd0);
    chk("z_cnt", 64'(fifo_count), 64'd0);

    // reset with two queued entries, busy=0x30
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 4, 0, 0, 0);
    step(1, 0, 0, 0, 1, 5, 0, 0, 0);
    step(1, 1, 2, 32'h2, 0, 0, 1, 4, 32'h4);
    step(1, 1, 2, 32'h2, 0, 0, 1, 5, 32'h5);
    chk("pr_busy", 64'(busy), 64'h30);
    chk("pr_cnt", 64'(fifo_count), 64'd2);
    step(0, 1, 2, 32'h2, 0, 0, 1, 6, 32'h6);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_cnt", 64'(fifo_count), 64'd0);
    chk("mr_we", 64'(write_en), 64'd0);
    chk("mr_rdy", 64'(mc_ready), 64'd1);

`ifdef WB_WAW_CHECK_EN
    step(1, 0, 0, 0, 1, 6, 0, 0, 0);
    step(1, 1, 6, 32'h66, 0, 0, 0, 0, 0);
    chk("waw_set", 64'(waw_err), 64'd1);
    idle();
    idle();
    chk("waw_hold", 64'(waw_err), 64'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("waw_rst", 64'(waw_err), 64'd0);
`endif

    // random traffic
    for (int i = 0; i < 800; i++) begin
      r   = ($urandom_range(63) != 0);
      we  = ($urandom_range(2) == 0);
      wr  = 5'($urandom_range(7));
      iss = ($urandom_range(3) == 0);
      ir  = 5'($urandom_range(7));
      mv  = ($urandom_range(1) == 0);
      mr  = 5'($urandom_range(7));
      step(r, we, wr, $urandom, iss, ir,
           mv, mr, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
